// File: rtl/sc_lives_pkg.sv
// Shared constants for the Frogger lives counter: FSM state codes and
// default game parameters.
package sc_lives_pkg;

   localparam logic [1:0] ST_ALIVE = 2'b00;
   localparam logic [1:0] ST_GRACE = 2'b01;
   localparam logic [1:0] ST_OVER  = 2'b10;

   localparam int LIVES_INIT_DEFAULT   = 3;
   localparam int LIVES_MAX_DEFAULT    = 7;
   // 1 s of invulnerability at 50 MHz
   localparam int GRACE_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/sc_lives_grace_timer.sv
// Loadable down-counter for the post-hit invulnerability window.
// Load wins over enable; the count holds at zero instead of wrapping.
module sc_lives_grace_timer #(
   parameter int GRACE_DATAWIDTH = 26
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       load_i,
   input  logic [GRACE_DATAWIDTH-1:0] load_val_i,
   input  logic                       en_i,
   output logic                       zero_o
);

   logic [GRACE_DATAWIDTH-1:0] count_q;
   logic [GRACE_DATAWIDTH-1:0] count_d;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - GRACE_DATAWIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/sc_lives_counter.sv
// Registered lives counter: edge-detected hits take a life and open a grace
// window, bonus pulses add lives up to a ceiling, zero lives holds until restart.
module sc_lives_counter
   import sc_lives_pkg::*;
#(
   parameter int LIVES_COUNTER_DATAWIDTH = 3,
   parameter int LIVES_INIT              = LIVES_INIT_DEFAULT,
   parameter int LIVES_MAX               = LIVES_MAX_DEFAULT,
   parameter int GRACE_CYCLES            = GRACE_CYCLES_DEFAULT,
   parameter int GRACE_DATAWIDTH         = 26
) (
   input  logic                               SC_LIVES_COUNTER_CLOCK_50,
   input  logic                               SC_LIVES_COUNTER_RESET_InLow,
   input  logic                               SC_LIVES_COUNTER_collision_InHigh,
   input  logic                               SC_LIVES_COUNTER_bonus_InHigh,
   input  logic                               SC_LIVES_COUNTER_restart_InHigh,
   output logic [LIVES_COUNTER_DATAWIDTH-1:0] SC_LIVES_COUNTER_data_OutBUS,
   output logic                               SC_LIVES_COUNTER_lost_OutHigh,
   output logic                               SC_LIVES_COUNTER_grace_OutHigh
);

   localparam int LW = LIVES_COUNTER_DATAWIDTH;
   localparam int TW = GRACE_DATAWIDTH;

   localparam logic [LW-1:0] INIT_V     = LW'(LIVES_INIT);
   localparam logic [LW-1:0] MAX_V      = LW'(LIVES_MAX);
   localparam logic [LW-1:0] ONE_V      = LW'(1);
   localparam logic [TW-1:0] GRACE_LOAD = TW'(GRACE_CYCLES - 1);

   logic          clk;
   logic          rst_n;
   logic          hit;

   logic [1:0]    state_q,  state_d;
   logic [LW-1:0] lives_q,  lives_d;
   logic          lost_q,   lost_d;
   logic          grace_q,  grace_d;
   logic          coll_q;

   logic          tmr_load;
   logic [TW-1:0] tmr_load_val;
   logic          tmr_en;
   logic          tmr_zero;

   assign clk   = SC_LIVES_COUNTER_CLOCK_50;
   assign rst_n = SC_LIVES_COUNTER_RESET_InLow;

   // A held collision level counts once: only a low-to-high transition is a hit.
   assign hit = SC_LIVES_COUNTER_collision_InHigh & ~coll_q;

   function automatic logic [LW-1:0] inc_sat(input logic [LW-1:0] v);
      return (v >= MAX_V) ? MAX_V : v + ONE_V;
   endfunction

   function automatic logic [LW-1:0] clamp_max(input logic [LW-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      lost_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      tmr_en       = 1'b0;

      if (SC_LIVES_COUNTER_restart_InHigh) begin
         state_d  = ST_ALIVE;
         lives_d  = INIT_V;
         tmr_load = 1'b1;
      end else begin
         case (state_q)
            ST_ALIVE: begin
               if (hit) begin
                  lost_d = 1'b1;
                  if (SC_LIVES_COUNTER_bonus_InHigh) begin
                     // Decrement and bonus cancel; the frog still gets its grace window.
                     lives_d      = clamp_max(lives_q);
                     state_d      = ST_GRACE;
                     tmr_load     = 1'b1;
                     tmr_load_val = GRACE_LOAD;
                  end else if (lives_q > ONE_V) begin
                     lives_d      = lives_q - ONE_V;
                     state_d      = ST_GRACE;
                     tmr_load     = 1'b1;
                     tmr_load_val = GRACE_LOAD;
                  end else begin
                     lives_d = '0;
                     state_d = ST_OVER;
                  end
               end else if (SC_LIVES_COUNTER_bonus_InHigh) begin
                  lives_d = inc_sat(lives_q);
               end
            end
            ST_GRACE: begin
               tmr_en = 1'b1;
               if (tmr_zero) begin
                  state_d = ST_ALIVE;
               end
               if (SC_LIVES_COUNTER_bonus_InHigh) begin
                  lives_d = inc_sat(lives_q);
               end
            end
            ST_OVER: begin
               lives_d = '0;
            end
            default: begin
               state_d = ST_ALIVE;
            end
         endcase
      end

      grace_d = (state_d == ST_GRACE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ALIVE;
         lives_q <= INIT_V;
         lost_q  <= 1'b0;
         grace_q <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         lost_q  <= lost_d;
         grace_q <= grace_d;
         // Also covers restart: a collision already held then is not a new hit.
         coll_q  <= SC_LIVES_COUNTER_collision_InHigh;
      end
   end

   sc_lives_grace_timer #(
      .GRACE_DATAWIDTH (TW)
   ) u_grace_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   assign SC_LIVES_COUNTER_data_OutBUS   = lives_q;
   assign SC_LIVES_COUNTER_lost_OutHigh  = lost_q;
   assign SC_LIVES_COUNTER_grace_OutHigh = grace_q;

endmodule

// File: tb/tb_sc_lives_counter.sv
// Directed bench for sc_lives_counter with a 4-cycle grace window.
module tb_sc_lives_counter;
   import sc_lives_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       coll;
   logic       bonus;
   logic       restart;
   logic [2:0] data;
   logic       lost;
   logic       grace;

   int         checks;
   int         errors;
   int         lost_cnt;
   int         grace_cnt;
   logic [2:0] exp_b;

   sc_lives_counter #(
      .LIVES_COUNTER_DATAWIDTH (3),
      .LIVES_INIT              (3),
      .LIVES_MAX               (7),
      .GRACE_CYCLES            (4),
      .GRACE_DATAWIDTH         (3)
   ) dut (
      .SC_LIVES_COUNTER_CLOCK_50         (clk),
      .SC_LIVES_COUNTER_RESET_InLow      (rst_n),
      .SC_LIVES_COUNTER_collision_InHigh (coll),
      .SC_LIVES_COUNTER_bonus_InHigh     (bonus),
      .SC_LIVES_COUNTER_restart_InHigh   (restart),
      .SC_LIVES_COUNTER_data_OutBUS      (data),
      .SC_LIVES_COUNTER_lost_OutHigh     (lost),
      .SC_LIVES_COUNTER_grace_OutHigh    (grace)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      coll    = 1'b0;
      bonus   = 1'b0;
      restart = 1'b0;

      #12;
      check("rst_data", 32'(data), 3);
      check("rst_lost", 32'(lost), 0);
      check("rst_grace", 32'(grace), 0);
      check("rst_state", 32'(dut.state_q), 32'(ST_ALIVE));
      rst_n = 1'b1;
      tick();

      // Three collision pulses, six cycles apart: 3 -> 2 -> 1 -> 0
      coll = 1'b1; tick();
      check("p1_data", 32'(data), 2);
      check("p1_lost", 32'(lost), 1);
      check("p1_grace", 32'(grace), 1);
      coll = 1'b0; tick();
      check("p1_lost_end", 32'(lost), 0);
      check("p1_grace_hold", 32'(grace), 1);
      repeat (4) tick();
      check("p1_grace_end", 32'(grace), 0);
      coll = 1'b1; tick();
      check("p2_data", 32'(data), 1);
      check("p2_lost", 32'(lost), 1);
      coll = 1'b0; tick();
      repeat (4) tick();
      coll = 1'b1; tick();
      check("p3_data", 32'(data), 0);
      check("p3_lost", 32'(lost), 1);
      check("p3_grace", 32'(grace), 0);
      check("p3_state", 32'(dut.state_q), 32'(ST_OVER));
      coll = 1'b0; tick();

      // OVER ignores bonus and hits
      bonus = 1'b1; tick();
      bonus = 1'b0;
      check("over_bonus", 32'(data), 0);
      coll = 1'b1; tick();
      check("over_hit_data", 32'(data), 0);
      check("over_hit_lost", 32'(lost), 0);

      // Restart with the collision still held is not a hit
      restart = 1'b1; tick();
      restart = 1'b0;
      check("rs_data", 32'(data), 3);
      check("rs_state", 32'(dut.state_q), 32'(ST_ALIVE));
      check("rs_lost", 32'(lost), 0);
      tick();
      check("rs_held_data", 32'(data), 3);
      check("rs_held_lost", 32'(lost), 0);
      coll = 1'b0; tick();

      // Collision held for 20 cycles: one decrement, grace for exactly 4 cycles
      lost_cnt  = 0;
      grace_cnt = 0;
      coll = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (lost)  lost_cnt++;
         if (grace) grace_cnt++;
      end
      coll = 1'b0; tick();
      check("held_data", 32'(data), 2);
      check("held_lost_cnt", 32'(lost_cnt), 1);
      check("held_grace_cnt", 32'(grace_cnt), 4);

      // Second edge inside GRACE ignored, edge six cycles later accepted
      restart = 1'b1; tick();
      restart = 1'b0;
      coll = 1'b1; tick();
      check("g_first", 32'(data), 2);
      coll = 1'b0; tick();
      coll = 1'b1; tick();
      check("g_ignored_data", 32'(data), 2);
      check("g_ignored_lost", 32'(lost), 0);
      coll = 1'b0; tick();
      tick();
      tick();
      coll = 1'b1; tick();
      check("g_after_data", 32'(data), 1);
      check("g_after_lost", 32'(lost), 1);
      coll = 1'b0; tick();

      // Five bonus pulses from 3 saturate at 7
      restart = 1'b1; tick();
      restart = 1'b0;
      exp_b = 3'd3;
      for (int i = 0; i < 5; i++) begin
         exp_b = (exp_b == 3'd7) ? 3'd7 : exp_b + 3'd1;
         bonus = 1'b1; tick();
         check("bonus_data", 32'(data), 32'(exp_b));
         bonus = 1'b0; tick();
      end

      // Hit and bonus together at the ceiling
      coll = 1'b1; bonus = 1'b1; tick();
      check("hb_max_data", 32'(data), 7);
      check("hb_max_lost", 32'(lost), 1);
      check("hb_max_grace", 32'(grace), 1);
      coll = 1'b0; bonus = 1'b0; tick();

      // Asynchronous reset between clock edges while in GRACE
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_data", 32'(data), 3);
      check("ar_grace", 32'(grace), 0);
      check("ar_lost", 32'(lost), 0);
      rst_n = 1'b1;
      tick();
      coll = 1'b1; tick();
      check("ar_hit_data", 32'(data), 2);
      check("ar_hit_lost", 32'(lost), 1);
      coll = 1'b0;
      repeat (5) tick();

      // Reach one life, then hit and bonus together
      coll = 1'b1; tick();
      check("one_data", 32'(data), 1);
      coll = 1'b0;
      repeat (5) tick();
      coll = 1'b1; bonus = 1'b1; tick();
      check("hb1_data", 32'(data), 1);
      check("hb1_lost", 32'(lost), 1);
      check("hb1_grace", 32'(grace), 1);
      check("hb1_state", 32'(dut.state_q), 32'(ST_GRACE));
      coll = 1'b0; bonus = 1'b0; tick();
      check("hb1_lost_end", 32'(lost), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_lives_counter.md
# sc_lives_counter

Registered lives counter for the Frogger game datapath. It starts each game with a fixed number of lives and subtracts one per frog collision. A post-hit grace window makes the frog invulnerable for a while, bonus events add lives, and once lives reach zero the block holds until a restart. Its count output feeds the lives comparator directly downstream, which raises the low-active game-over signal when the count is zero.

## Interface
- LIVES_COUNTER_DATAWIDTH, 3: width of the lives count.
- LIVES_INIT, 3: lives loaded at reset and at restart.
- LIVES_MAX, 7: saturation ceiling for bonus lives; must be ≤ 2^LIVES_COUNTER_DATAWIDTH−1.
- GRACE_CYCLES, 50_000_000: length of the invulnerability window in clocks (1 s at 50 MHz); must be ≥ 1.
- GRACE_DATAWIDTH, 26: grace timer width; must hold GRACE_CYCLES−1.
- SC_LIVES_COUNTER_CLOCK_50 in 1: system clock.
- SC_LIVES_COUNTER_RESET_InLow in 1: reset, asynchronous, active-low.
- SC_LIVES_COUNTER_collision_InHigh in 1: frog/obstacle collision level, synchronous to the clock.
- SC_LIVES_COUNTER_bonus_InHigh in 1: one-cycle bonus-life pulse (level cleared).
- SC_LIVES_COUNTER_restart_InHigh in 1: one-cycle new-game request.
- SC_LIVES_COUNTER_data_OutBUS out LIVES_COUNTER_DATAWIDTH: current lives; feeds the comparator.
- SC_LIVES_COUNTER_lost_OutHigh out 1: one-cycle pulse when a life is taken.
- SC_LIVES_COUNTER_grace_OutHigh out 1: high while the frog is invulnerable.

## Operation
- All outputs are registered.
- Reset values: data = LIVES_INIT, lost = 0, grace = 0, state = ALIVE, timer = 0, edge register = 0.
- Collision is edge-detected: a hit is collision high this cycle while the previous sample was low. A held level counts once.
- ALIVE:
  - Hit, lives > 1: lives−1, lost pulse, go to GRACE with timer = GRACE_CYCLES−1.
  - Hit, lives == 1: lives = 0, lost pulse, go to OVER.
- GRACE:
  - Hits are ignored; grace = 1.
  - Timer decrements each cycle. When the timer is 0, go to ALIVE and set grace = 0.
- OVER:
  - Lives stay at 0; hits and bonus are ignored.
  - Only restart or reset leaves this state.
- Bonus in ALIVE or GRACE: lives+1, saturating at LIVES_MAX. Bonus does not change the state or the timer.
- Hit and bonus in the same ALIVE cycle:
  - Lives are unchanged.
  - lost pulses and the block enters GRACE, even when lives == 1.
  - At LIVES_MAX the result is LIVES_MAX (saturation is applied after the decrement).
- Restart (highest priority, synchronous, any state):
  - lives = LIVES_INIT, state = ALIVE, timer = 0, lost = 0, grace = 0.
  - The edge register loads the current collision level, so a collision already held at restart is not a hit.
- Reset asserted mid-GRACE or mid-OVER returns the block to reset values immediately, without waiting for a clock.
- Arithmetic:
  - Lives arithmetic is unsigned at LIVES_COUNTER_DATAWIDTH; it never wraps below 0 or above LIVES_MAX.
  - The timer is unsigned at GRACE_DATAWIDTH.

## Timing
- Hit sampled at edge N: data and lost change after edge N; lost is high for exactly one cycle (N to N+1).
- Grace high from edge N to edge N+GRACE_CYCLES, i.e. exactly GRACE_CYCLES cycles. A hit sampled at edge N+GRACE_CYCLES+1 or later is accepted; hits at earlier edges are ignored.
- Bonus sampled at edge M: data changes after edge M, with one-cycle latency.
- Restart sampled at edge R: reset values appear after R, with one-cycle latency.
- Comparator path: zero lives reaches the comparator one cycle after the final hit edge.

## Structure
- Shared package `sc_lives_pkg` holds:
  - State encoding: ALIVE = 2'b00, GRACE = 2'b01, OVER = 2'b10. Any other code recovers to ALIVE.
  - Default constants: LIVES_INIT, LIVES_MAX, GRACE_CYCLES.
- One sub-module, `sc_lives_grace_timer`: a loadable down-counter with load, enable and zero-flag output. The FSM and lives register stay in the top.

## Test plan
- Reset, then 3 separate collision pulses, 6 cycles apart, with GRACE_CYCLES = 4 → data 3→2→1→0, three lost pulses, state reaches OVER after the third.
- Collision held high for 20 cycles, GRACE_CYCLES = 4 → exactly one decrement, 3→2; grace high for exactly 4 cycles.
- Second collision edge 2 cycles after the first (inside GRACE) → ignored, data stays 2. Edge 6 cycles after → data 1.
- 5 bonus pulses from data = 3, LIVES_MAX = 7 → 4, 5, 6, 7, 7 (saturates). Hit and bonus in the same cycle at data = 1 → data 1, lost = 1, grace = 1.
- In OVER, apply a bonus and a collision edge → data stays 0. Restart with collision held high → data 3, state ALIVE, no lost pulse.
- Reset asserted mid-GRACE, between clock edges → data 3 and grace 0 immediately. Release, then a collision edge → data 2.
